// File: rtl/apb_interrupt_controller_pkg.sv
// ============================================================================
// Module : InterruptControllerRegs (package)
// Desc   : Register offsets and address decode shared by the interrupt
//          controller RTL and firmware-header generation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package InterruptControllerRegs;

    localparam int unsigned C_DATA_W = 32;
    localparam logic [C_DATA_W-1:0] C_NONE = 32'hFFFF_FFFF;

    typedef enum logic [7:0] {
        IRQ_RAW     = 8'h00,
        IRQ_PENDING = 8'h04,
        IRQ_ENABLE  = 8'h08,
        IRQ_MODE    = 8'h0C,
        IRQ_ACTIVE  = 8'h10,
        IRQ_SWTRIG  = 8'h14,
        IRQ_HIGHEST = 8'h18
    } irq_reg_e;

    typedef struct packed {
        logic raw;
        logic pending;
        logic enable;
        logic mode;
        logic active;
        logic swtrig;
        logic highest;
    } reg_sel_t;

    // One-hot register select from the low address byte; all zero when unmapped.
    function automatic reg_sel_t decode_offset(input logic [7:0] off);
        reg_sel_t s;
        s = '0;
        case (off)
            IRQ_RAW:     s.raw     = 1'b1;
            IRQ_PENDING: s.pending = 1'b1;
            IRQ_ENABLE:  s.enable  = 1'b1;
            IRQ_MODE:    s.mode    = 1'b1;
            IRQ_ACTIVE:  s.active  = 1'b1;
            IRQ_SWTRIG:  s.swtrig  = 1'b1;
            IRQ_HIGHEST: s.highest = 1'b1;
            default:     s         = '0;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_interrupt_controller_prio.sv
// ============================================================================
// Module : PriorityEncoder
// Desc   : Index of the lowest-numbered set bit of in_vec; valid when any set.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module PriorityEncoder #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_vec,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    // Scan downward so the last hit, the lowest index, wins.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                index = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_interrupt_controller.sv
// ============================================================================
// Module : apb_interrupt_controller
// Desc   : APB completer aggregating NUM_IRQ level/edge interrupt sources into
//          a single registered irq line. ADDR_WIDTH must be at least 8.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_interrupt_controller
    import InterruptControllerRegs::*;
#(
    parameter int NUM_IRQ    = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [NUM_IRQ-1:0]    irq_in,
    output logic                  irq
);

    localparam int          c_idx_w = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [31:0] c_mask  = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                      : ((32'd1 << NUM_IRQ) - 32'd1);

    logic [31:0]        r_enable;
    logic [31:0]        r_mode;
    logic [31:0]        r_latched;
    logic [31:0]        r_irq_prev;
    logic [31:0]        r_prdata;
    logic               r_pready;
    logic               r_pslverr;
    logic               r_irq;

    logic [31:0]        w_irq_in;
    logic               w_addr_hi_zero;
    reg_sel_t           w_sel;
    logic               w_mapped;
    logic               w_err;
    logic               w_setup;
    logic               w_wr;
    logic [31:0]        w_wdata;
    logic [31:0]        w_pending;
    logic [31:0]        w_active;
    logic [c_idx_w-1:0] w_prio_idx;
    logic               w_prio_valid;
    logic [31:0]        w_highest;
    logic [31:0]        w_rise;
    logic [31:0]        w_clr;
    logic [31:0]        w_sw;
    logic [31:0]        w_mode_nxt;
    logic [31:0]        w_latched_nxt;
    logic [31:0]        w_rdata;

    generate
        if (NUM_IRQ < 32) begin : g_in_pad
            assign w_irq_in = {{(32 - NUM_IRQ){1'b0}}, irq_in};
        end else begin : g_in_full
            assign w_irq_in = irq_in;
        end

        if (ADDR_WIDTH > 8) begin : g_addr_hi
            assign w_addr_hi_zero = ~|paddr[ADDR_WIDTH-1:8];
        end else begin : g_addr_lo
            assign w_addr_hi_zero = 1'b1;
        end
    endgenerate

    assign w_sel    = decode_offset(paddr[7:0]);
    assign w_mapped = w_addr_hi_zero & (|w_sel);
    assign w_err    = ~w_mapped | (pwrite & (w_sel.raw | w_sel.active | w_sel.highest));
    assign w_setup  = psel & ~penable;
    // A write commits only in the access phase of a transfer whose setup
    // phase was seen since reset and was accepted without error.
    assign w_wr     = psel & penable & pwrite & r_pready & ~r_pslverr & w_addr_hi_zero;
    assign w_wdata  = pwdata & c_mask;

    assign w_pending = (r_mode & r_latched) | (~r_mode & w_irq_in);
    assign w_active  = w_pending & r_enable;

    PriorityEncoder #(
        .WIDTH (NUM_IRQ)
    ) u_prio (
        .in_vec (w_active[NUM_IRQ-1:0]),
        .index  (w_prio_idx),
        .valid  (w_prio_valid)
    );

    assign w_highest = w_prio_valid ? 32'(w_prio_idx) : C_NONE;

    // Set sources beat a coincident W1C; bits leaving edge mode drop their latch.
    assign w_rise        = w_irq_in & ~r_irq_prev & r_mode;
    assign w_clr         = (w_wr && w_sel.pending) ? (w_wdata & r_mode) : 32'd0;
    assign w_sw          = (w_wr && w_sel.swtrig)  ? (w_wdata & r_mode) : 32'd0;
    assign w_mode_nxt    = (w_wr && w_sel.mode)    ? w_wdata : r_mode;
    assign w_latched_nxt = ((r_latched & ~w_clr) | w_rise | w_sw) & w_mode_nxt;

    always_comb begin
        w_rdata = '0;
        if (w_sel.raw)          w_rdata = w_irq_in;
        else if (w_sel.pending) w_rdata = w_pending;
        else if (w_sel.enable)  w_rdata = r_enable;
        else if (w_sel.mode)    w_rdata = r_mode;
        else if (w_sel.active)  w_rdata = w_active;
        else if (w_sel.highest) w_rdata = w_highest;
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_enable   <= '0;
            r_mode     <= '0;
            r_latched  <= '0;
            r_irq_prev <= '1;
            r_prdata   <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_irq_prev <= w_irq_in;
            r_latched  <= w_latched_nxt;
            r_mode     <= w_mode_nxt;
            r_irq      <= |w_active;
            if (w_wr && w_sel.enable) begin
                r_enable <= w_wdata;
            end
            // Response is prepared during setup so pready is up for the
            // whole first access-phase cycle.
            if (w_setup) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_err;
                r_prdata  <= (pwrite || w_err) ? 32'd0 : w_rdata;
            end else begin
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
                r_prdata  <= '0;
            end
        end
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign irq     = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_apb_interrupt_controller.sv
// ============================================================================
// Module : tb_apb_interrupt_controller
// Desc   : Scoreboard bench for apb_interrupt_controller with a per-bit
//          behavioural reference model and randomized APB/irq stimulus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_interrupt_controller;

    localparam int          N    = 8;
    localparam int          AW   = 10;
    localparam logic [31:0] MASK = (32'd1 << N) - 32'd1;

    localparam bit [31:0] A_RAW = 32'h00, A_PEND = 32'h04, A_EN = 32'h08, A_MODE = 32'h0C;
    localparam bit [31:0] A_ACT = 32'h10, A_SW = 32'h14, A_HIGH = 32'h18;

    logic          pclk     = 1'b0;
    logic          preset_n = 1'b0;
    logic          psel     = 1'b0;
    logic          penable  = 1'b0;
    logic          pwrite   = 1'b0;
    logic [AW-1:0] paddr    = '0;
    logic [31:0]   pwdata   = '0;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic [N-1:0]  irq_in   = '0;
    logic          irq;

    always #5 pclk = ~pclk;

    apb_interrupt_controller #(
        .NUM_IRQ    (N),
        .ADDR_WIDTH (AW)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .irq_in   (irq_in),
        .irq      (irq)
    );

    typedef struct {
        bit          wr;
        bit          err;
        bit [31:0]   addr;
        logic [31:0] data;
    } resp_t;

    resp_t rq[$];
    bit    iq[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model state, one bit per source.
    bit [31:0] m_en, m_mode, m_latch, m_prev;
    bit        acc_wr;
    bit [31:0] acc_addr, acc_data;

    function automatic bit [31:0] in32();
        return {{(32 - N){1'b0}}, irq_in} & MASK;
    endfunction

    function automatic bit [31:0] m_pend();
        bit [31:0] p = '0;
        for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_latch[i] : irq_in[i];
        return p;
    endfunction

    function automatic bit [31:0] m_active();
        return m_pend() & m_en;
    endfunction

    function automatic bit [31:0] m_highest();
        bit [31:0] a = m_active();
        for (int i = 0; i < N; i++) if (a[i]) return 32'(i);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic bit is_mapped(input bit [31:0] a);
        return a inside {A_RAW, A_PEND, A_EN, A_MODE, A_ACT, A_SW, A_HIGH};
    endfunction

    function automatic bit exp_err(input bit wr, input bit [31:0] a);
        return !is_mapped(a) || (wr && (a inside {A_RAW, A_ACT, A_HIGH}));
    endfunction

    function automatic bit [31:0] exp_read(input bit [31:0] a);
        case (a)
            A_RAW:   return in32();
            A_PEND:  return m_pend();
            A_EN:    return m_en;
            A_MODE:  return m_mode;
            A_ACT:   return m_active();
            A_HIGH:  return m_highest();
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across the coming clock edge using the inputs now driven.
    task automatic model_edge();
        bit [31:0] cur, nl, nen, nmode;
        bit        set, keep;
        if (!preset_n) begin
            m_en = '0; m_mode = '0; m_latch = '0; m_prev = '1;
            iq.push_back(1'b0);
        end else begin
            iq.push_back(|m_active());
            cur = in32(); nl = '0; nen = m_en; nmode = m_mode;
            for (int i = 0; i < N; i++) begin
                set  = m_mode[i] && cur[i] && !m_prev[i];
                keep = m_latch[i];
                if (acc_wr && m_mode[i]) begin
                    if (acc_addr == A_PEND && acc_data[i]) keep = 1'b0;
                    if (acc_addr == A_SW && acc_data[i])   set  = 1'b1;
                end
                nl[i] = keep || set;
            end
            if (acc_wr && acc_addr == A_EN)   nen   = acc_data & MASK;
            if (acc_wr && acc_addr == A_MODE) nmode = acc_data & MASK;
            for (int i = 0; i < N; i++) if (!nmode[i]) nl[i] = 1'b0;
            m_latch = nl; m_en = nen; m_mode = nmode; m_prev = cur;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic apb_irq(input bit wr, input bit [31:0] a, input bit [31:0] d,
                           input logic [N-1:0] acc_in);
        resp_t r;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a[AW-1:0]; pwdata = d;
        r.wr = wr; r.addr = a; r.err = exp_err(wr, a); r.data = exp_read(a);
        rq.push_back(r);
        tick();
        penable = 1'b1; irq_in = acc_in;
        acc_wr = wr && !r.err; acc_addr = a; acc_data = d;
        tick();
        acc_wr = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input bit [31:0] a, input bit [31:0] d);
        apb_irq(1'b1, a, d, irq_in);
    endtask

    task automatic rd(input bit [31:0] a);
        apb_irq(1'b0, a, 32'd0, irq_in);
    endtask

    // APB response monitor: sampled late in each cycle, well away from posedge.
    initial begin
        resp_t r;
        forever begin
            @(negedge pclk);
            #4;
            if (preset_n && psel && penable) begin
                total++;
                if (!pready) begin
                    bad++;
                    $display("FAIL pready addr=%h got=0 want=1", paddr);
                    if (rq.size() > 0) void'(rq.pop_front());
                end else if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_response addr=%h got=pready want=none", paddr);
                end else begin
                    r = rq.pop_front();
                    if (pslverr !== r.err) begin
                        bad++;
                        $display("FAIL pslverr addr=%h wr=%0b got=%0b want=%0b",
                                 r.addr, r.wr, pslverr, r.err);
                    end else if (!r.wr && !r.err) begin
                        total++;
                        if (prdata !== r.data) begin
                            bad++;
                            $display("FAIL prdata addr=%h got=%h want=%h",
                                     r.addr, prdata, r.data);
                        end
                    end
                end
            end
        end
    end

    // irq monitor: one expected value per clock edge.
    initial begin
        bit e;
        forever begin
            @(posedge pclk);
            #1;
            if (iq.size() > 0) begin
                e = iq.pop_front();
                total++;
                if (irq !== e) begin
                    bad++;
                    $display("FAIL irq t=%0t got=%0b want=%0b", $time, irq, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [31:0] addrs [10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                                  32'h14, 32'h18, 32'h1C, 32'h20, 32'h3FC};
        bit [31:0] a;
        @(negedge pclk);
        idle(3);
        preset_n = 1'b1;
        tick();

        // Reset state of every register.
        for (int i = 0; i < 7; i++) rd(addrs[i]);

        // Level mode follows irq_in with one cycle of irq latency.
        wr(A_MODE, 32'h0); wr(A_EN, 32'h01);
        irq_in = 8'h01; idle(2); rd(A_PEND);
        irq_in = 8'h00; idle(2); rd(A_PEND);

        // Edge mode latches a one-cycle pulse until W1C.
        wr(A_MODE, 32'h04); wr(A_EN, 32'h04);
        irq_in = 8'h04; tick(); irq_in = 8'h00; idle(3);
        rd(A_PEND); wr(A_PEND, 32'h04); idle(2); rd(A_PEND);

        // Rising edge coincident with W1C of the same bit keeps it set.
        wr(A_MODE, 32'h08); wr(A_EN, 32'h08);
        apb_irq(1'b1, A_PEND, 32'h08, 8'h08);
        rd(A_PEND); irq_in = 8'h00; idle(1);

        // Software trigger and HIGHEST.
        wr(A_MODE, 32'hFF); wr(A_SW, 32'h30); wr(A_EN, 32'h20);
        rd(A_ACT); rd(A_HIGH); rd(A_PEND);
        wr(A_EN, 32'h0); rd(A_HIGH); idle(2);

        // Error responses leave state untouched.
        rd(32'h1C); wr(A_RAW, 32'h55); wr(A_ACT, 32'hFF); wr(A_HIGH, 32'hFF);
        rd(A_RAW); rd(A_EN); rd(A_MODE); rd(A_SW); rd(A_PEND);

        // Inputs high through reset release do not form edges.
        irq_in = 8'hFF; preset_n = 1'b0; idle(2); preset_n = 1'b1; tick();
        wr(A_MODE, 32'hFF); wr(A_EN, 32'hFF); idle(2);
        rd(A_PEND); rd(A_HIGH);

        // Reset asserted in the access phase of an ENABLE write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h008; pwdata = 32'hFF;
        tick();
        penable = 1'b1; preset_n = 1'b0;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        tick();
        preset_n = 1'b1; tick();
        rd(A_EN); rd(A_MODE);

        // Randomized traffic.
        irq_in = '0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) irq_in = N'($urandom);
            a = addrs[$urandom_range(0, 9)];
            case ($urandom_range(0, 5))
                0:       idle(1);
                1, 2:    rd(a);
                3:       apb_irq(1'b1, a, $urandom, N'($urandom));
                default: wr(a, $urandom);
            endcase
        end
        idle(3);

        if (rq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL response_timeout got=%0d_outstanding want=0", rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
